// File: rtl/fir_mac_if.sv
// Handshake and coefficient-write bundle for the time-multiplexed 4-tap FIR.
// The master drives samples, coefficient writes and out_ready; the slave is the filter.
interface fir_mac_if;
  logic signed [3:0] x;
  logic              in_valid;
  logic              in_ready;
  logic              coef_we;
  logic        [1:0] coef_addr;
  logic signed [3:0] coef_data;
  logic              coef_busy;
  logic signed [7:0] y;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output x, in_valid, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, coef_busy, y, out_valid
  );

  modport slave (
    input  x, in_valid, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, coef_busy, y, out_valid
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// 4-tap FIR filter sharing a single signed 4x4 multiplier across taps.
// Each accepted sample takes four MAC cycles, then the result is held until taken.
module fir_mac_scheduler (
  input  logic       clk,
  input  logic       rst,
  fir_mac_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t            state;
  logic        [1:0] k;
  logic signed [7:0] acc;
  logic signed [3:0] d [4];
  logic signed [3:0] h [4];
  logic signed [7:0] y_r;
  logic              out_valid_r;
  logic              in_ready_r;
  logic              coef_busy_r;

  logic signed [7:0] h_ext;
  logic signed [7:0] d_ext;
  logic signed [7:0] prod;
  logic signed [7:0] acc_next;

  // Only the low 8 bits of the product matter, since the sum wraps modulo 2^8.
  assign h_ext    = {{4{h[k][3]}}, h[k]};
  assign d_ext    = {{4{d[k][3]}}, d[k]};
  assign prod     = h_ext * d_ext;
  assign acc_next = acc + prod;

  // NOTE: the small delay-line and coefficient arrays are plain flops, so they
  // are reset like any other register; a RAM-style array would not be.
  // NOTE: all state here uses non-blocking assignment so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= 2'd0;
      acc         <= 8'sd0;
      d           <= '{default: 4'sd0};
      h           <= '{4'sd1, 4'sd2, 4'sd3, 4'sd4};
      y_r         <= 8'sd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      coef_busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A write in the same cycle as a sample lands before the first MAC.
          if (bus.coef_we) h[bus.coef_addr] <= bus.coef_data;
          if (bus.in_valid) begin
            d[3]        <= d[2];
            d[2]        <= d[1];
            d[1]        <= d[0];
            d[0]        <= bus.x;
            acc         <= 8'sd0;
            k           <= 2'd0;
            state       <= MAC;
            in_ready_r  <= 1'b0;
            coef_busy_r <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= k + 2'd1;
          if (k == 2'd3) begin
            y_r         <= acc_next;
            out_valid_r <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            y_r         <= 8'sd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            coef_busy_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          y_r         <= 8'sd0;
          in_ready_r  <= 1'b1;
          coef_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y         = y_r;
  assign bus.out_valid = out_valid_r;
  assign bus.in_ready  = in_ready_r;
  assign bus.coef_busy = coef_busy_r;

endmodule
